// File: rtl/hazard_if.sv
// Handshake bundle between the MIPS datapath and the hazard/sequencing controller.
// The datapath side drives the ID/EX decode information; the controller answers with
// pipeline enables, forwarding selects, halt status and statistics.
interface hazard_if #(
    parameter int unsigned CNT_W = 16
);
    // ID-stage decode of the instruction being issued
    logic [4:0]       id_ra;
    logic [4:0]       id_rb;
    logic             id_use_a;
    logic             id_use_b;
    logic [4:0]       id_rw;
    logic             id_regwrite;
    logic             id_load;

    // EX-stage resolution
    logic             ex_jump;
    logic             ex_syscall;
    logic [31:0]      ex_v0;

    // Resume from HALT
    logic             go;

    // Pipeline control
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             j_bub;

    // Forwarding selects for the instruction in EX
    logic             A_MEM;
    logic             A_WB;
    logic             B_MEM;
    logic             B_WB;

    // Status and statistics
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output id_ra, id_rb, id_use_a, id_use_b, id_rw, id_regwrite, id_load,
        output ex_jump, ex_syscall, ex_v0, go,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, j_bub,
        input  A_MEM, A_WB, B_MEM, B_WB,
        input  halted, stall_cnt, flush_cnt, retire_cnt
    );

    modport slave (
        input  id_ra, id_rb, id_use_a, id_use_b, id_rw, id_regwrite, id_load,
        input  ex_jump, ex_syscall, ex_v0, go,
        output pc_en, ifid_en, ifid_flush, idex_bubble, j_bub,
        output A_MEM, A_WB, B_MEM, B_WB,
        output halted, stall_cnt, flush_cnt, retire_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS core.
// Tracks EX/MEM/WB destinations, produces registered forwarding selects, inserts a
// single stall per load-use, flushes on taken jumps and halts on the exit syscall.
module hazard_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] EXIT_CODE = 32'h0000_000A
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave bus
);

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rw;
        logic       regwrite;
        logic       load;
    } trk_t;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    // A tracker only produces a value if it really writes a non-zero register.
    function automatic logic trk_hit(input trk_t t, input logic [4:0] r);
        return t.valid && t.regwrite && (t.rw != 5'd0) && (t.rw == r);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CntMax) ? c : c + CntOne;
    endfunction

    state_e           state_q;
    logic             halted_q;
    trk_t             ex_q, mem_q, wb_q;
    logic             a_mem_q, a_wb_q, b_mem_q, b_wb_q;
    logic             a_mem_d, a_wb_d, b_mem_d, b_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;

    logic run;
    logic a_hit_ex, b_hit_ex;
    logic load_use;
    logic jump;
    logic halt_req;
    logic pc_en, ifid_en, ifid_flush, bubble, j_bub;
    trk_t ex_d;

    // Hazard detection, pipeline control and next-state of forwarding selects
    always_comb begin
        run      = (state_q == StRun);
        a_hit_ex = bus.id_use_a && trk_hit(ex_q, bus.id_ra);
        b_hit_ex = bus.id_use_b && trk_hit(ex_q, bus.id_rb);
        load_use = run && ex_q.load && (a_hit_ex || b_hit_ex);
        jump     = run && bus.ex_jump;
        halt_req = run && bus.ex_syscall && (bus.ex_v0 == EXIT_CODE) && !bus.ex_jump;

        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        bubble     = 1'b0;
        j_bub      = 1'b0;
        if (!run) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            bubble  = 1'b1;
        end else if (jump) begin
            // Jump wins over load-use: the stalled ID instruction is discarded anyway.
            j_bub      = 1'b1;
            ifid_flush = 1'b1;
            bubble     = 1'b1;
        end else if (load_use) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            bubble  = 1'b1;
        end

        // MEM-stage source has priority over WB-stage source.
        a_mem_d = a_hit_ex;
        a_wb_d  = bus.id_use_a && !a_hit_ex && trk_hit(mem_q, bus.id_ra);
        b_mem_d = b_hit_ex;
        b_wb_d  = bus.id_use_b && !b_hit_ex && trk_hit(mem_q, bus.id_rb);
        if (bubble) begin
            a_mem_d = 1'b0;
            a_wb_d  = 1'b0;
            b_mem_d = 1'b0;
            b_wb_d  = 1'b0;
        end

        ex_d = bubble ? '0 : '{valid: 1'b1, rw: bus.id_rw,
                               regwrite: bus.id_regwrite, load: bus.id_load};
    end

    // Tracker shift and forwarding-select registers; frozen while halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            a_mem_q <= 1'b0;
            a_wb_q  <= 1'b0;
            b_mem_q <= 1'b0;
            b_wb_q  <= 1'b0;
        end else if (run) begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            a_mem_q <= a_mem_d;
            a_wb_q  <= a_wb_d;
            b_mem_q <= b_mem_d;
            b_wb_q  <= b_wb_d;
        end
    end

    // RUN/HALT sequencing with registered halted flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (halt_req) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end
                end
                StHalt: begin
                    if (bus.go) begin
                        state_q  <= StRun;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StRun;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics counters, only advancing in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else if (run) begin
            if (wb_q.valid) begin
                retire_cnt_q <= sat_inc(retire_cnt_q);
            end
            if (jump) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end else if (load_use) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    // Control outputs show their reset values as soon as rst rises, not at the next edge.
    assign bus.pc_en       = rst | pc_en;
    assign bus.ifid_en     = rst | ifid_en;
    assign bus.ifid_flush  = !rst && ifid_flush;
    assign bus.idex_bubble = !rst && bubble;
    assign bus.j_bub       = !rst && j_bub;

    assign bus.A_MEM = a_mem_q;
    assign bus.A_WB  = a_wb_q;
    assign bus.B_MEM = b_mem_q;
    assign bus.B_WB  = b_wb_q;

    assign bus.halted     = halted_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
    assign bus.retire_cnt = retire_cnt_q;

    // WB destination fields and the MEM load flag are carried for completeness only.
    logic unused_trk;
    assign unused_trk = ^{wb_q.rw, wb_q.regwrite, wb_q.load, mem_q.load};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run
// against a stage-list reference model.
module tb_hazard_ctrl;

    localparam int unsigned CntW     = 4;
    localparam logic [31:0] ExitCode = 32'h0000_000A;
    localparam int          CntMax   = (1 << CntW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    hazard_if #(.CNT_W(CntW)) bus ();

    hazard_ctrl #(
        .CNT_W    (CntW),
        .EXIT_CODE(ExitCode)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // {pc_en, ifid_en, ifid_flush, idex_bubble, j_bub}
    function automatic logic [4:0] ctrl_vec();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.j_bub};
    endfunction

    // {A_MEM, A_WB, B_MEM, B_WB}
    function automatic logic [3:0] fwd_vec();
        return {bus.A_MEM, bus.A_WB, bus.B_MEM, bus.B_WB};
    endfunction

    task automatic set_id(input logic [4:0] ra, input logic [4:0] rb, input logic ua,
                          input logic ub, input logic [4:0] rw, input logic wr,
                          input logic ld);
        bus.id_ra       = ra;
        bus.id_rb       = rb;
        bus.id_use_a    = ua;
        bus.id_use_b    = ub;
        bus.id_rw       = rw;
        bus.id_regwrite = wr;
        bus.id_load     = ld;
    endtask

    task automatic set_ex(input logic jmp, input logic sys, input logic [31:0] v0);
        bus.ex_jump    = jmp;
        bus.ex_syscall = sys;
        bus.ex_v0      = v0;
    endtask

    task automatic idle();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_ex(1'b0, 1'b0, 32'd0);
        bus.go = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #2;
        n_vec++;
        if (ctrl_vec() !== 5'b11000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want %b", ctrl_vec(), 5'b11000);
        end
        n_vec++;
        if ({fwd_vec(), bus.halted} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_fwd_halt: got %b want %b", {fwd_vec(), bus.halted}, 5'b0);
        end
        n_vec++;
        if ({bus.stall_cnt, bus.flush_cnt, bus.retire_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_cnt: got %h want 0",
                     {bus.stall_cnt, bus.flush_cnt, bus.retire_cnt});
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_forward();
        do_reset();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3,$1,$2
        tick();
        set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);  // sub $4,$3,$5
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (fwd_vec() !== 4'b1000) begin
            n_err++;
            $display("FAIL fwd_mem: got %b want %b", fwd_vec(), 4'b1000);
        end
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3,$1,$2
        tick();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);  // independent
        tick();
        set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);  // sub $4,$3,$3
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (fwd_vec() !== 4'b0101) begin
            n_err++;
            $display("FAIL fwd_wb: got %b want %b", fwd_vec(), 4'b0101);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);  // lw $8,0($0)
        tick();
        set_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);  // add $9,$8,$8
        @(negedge clk);
        n_vec++;
        if (ctrl_vec() !== 5'b00010) begin
            n_err++;
            $display("FAIL lu_stall: got %b want %b", ctrl_vec(), 5'b00010);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (ctrl_vec() !== 5'b11000) begin
            n_err++;
            $display("FAIL lu_single: got %b want %b", ctrl_vec(), 5'b11000);
        end
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (fwd_vec() !== 4'b0101) begin
            n_err++;
            $display("FAIL lu_fwd: got %b want %b", fwd_vec(), 4'b0101);
        end
        n_vec++;
        if (bus.stall_cnt !== CntW'(1)) begin
            n_err++;
            $display("FAIL lu_cnt: got %0d want 1", bus.stall_cnt);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);  // lw $0 (writes $0)
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // reads $0,$0
        @(negedge clk);
        n_vec++;
        if (ctrl_vec() !== 5'b11000) begin
            n_err++;
            $display("FAIL zero_nostall: got %b want %b", ctrl_vec(), 5'b11000);
        end
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if (fwd_vec() !== 4'b0000) begin
            n_err++;
            $display("FAIL zero_fwd: got %b want %b", fwd_vec(), 4'b0000);
        end
    endtask

    task automatic test_jump_over_stall();
        do_reset();
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        set_ex(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if (ctrl_vec() !== 5'b11111) begin
            n_err++;
            $display("FAIL jmp_ctrl: got %b want %b", ctrl_vec(), 5'b11111);
        end
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if ({bus.flush_cnt, bus.stall_cnt} !== {CntW'(1), CntW'(0)}) begin
            n_err++;
            $display("FAIL jmp_cnt: got flush=%0d stall=%0d want flush=1 stall=0",
                     bus.flush_cnt, bus.stall_cnt);
        end
        n_vec++;
        if (fwd_vec() !== 4'b0000) begin
            n_err++;
            $display("FAIL jmp_fwd: got %b want %b", fwd_vec(), 4'b0000);
        end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (5) tick();
        set_ex(1'b0, 1'b1, 32'd10);
        @(negedge clk);
        n_vec++;
        if ({bus.halted, ctrl_vec()} !== 6'b011000) begin
            n_err++;
            $display("FAIL halt_sys_cycle: got %b want %b", {bus.halted, ctrl_vec()}, 6'b011000);
        end
        tick();
        set_ex(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.halted, ctrl_vec()} !== 6'b100010) begin
                n_err++;
                $display("FAIL halt_hold[%0d]: got %b want %b", i, {bus.halted, ctrl_vec()},
                         6'b100010);
            end
            n_vec++;
            if (bus.retire_cnt !== CntW'(3)) begin
                n_err++;
                $display("FAIL halt_retire[%0d]: got %0d want 3", i, bus.retire_cnt);
            end
            tick();
        end
        bus.go = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_go_cycle: got %b want 1", bus.halted);
        end
        tick();
        bus.go = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.halted, ctrl_vec()} !== 6'b011000) begin
            n_err++;
            $display("FAIL halt_resume: got %b want %b", {bus.halted, ctrl_vec()}, 6'b011000);
        end
        set_ex(1'b0, 1'b1, 32'd1);
        tick();
        set_ex(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if ({bus.halted, ctrl_vec()} !== 6'b011000) begin
            n_err++;
            $display("FAIL halt_other_v0: got %b want %b", {bus.halted, ctrl_vec()}, 6'b011000);
        end
    endtask

    task automatic test_async_reset();
        // Reset while halted
        do_reset();
        set_ex(1'b0, 1'b1, 32'd10);
        tick();
        set_ex(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if (bus.halted !== 1'b1) begin
            n_err++;
            $display("FAIL ar_enter_halt: got %b want 1", bus.halted);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.halted, ctrl_vec()} !== 6'b011000) begin
            n_err++;
            $display("FAIL ar_halt_now: got %b want %b", {bus.halted, ctrl_vec()}, 6'b011000);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.pc_en !== 1'b1) begin
            n_err++;
            $display("FAIL ar_halt_after: got %b want 1", bus.pc_en);
        end
        // Reset in the middle of a load-use stall
        do_reset();
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if (bus.pc_en !== 1'b0) begin
            n_err++;
            $display("FAIL ar_stall_setup: got %b want 0", bus.pc_en);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ctrl_vec(), fwd_vec(), bus.stall_cnt} !== {5'b11000, 4'b0000, CntW'(0)}) begin
            n_err++;
            $display("FAIL ar_stall_now: got %b want %b", {ctrl_vec(), fwd_vec(), bus.stall_cnt},
                     {5'b11000, 4'b0000, CntW'(0)});
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.pc_en !== 1'b1) begin
            n_err++;
            $display("FAIL ar_stall_after: got %b want 1", bus.pc_en);
        end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        set_ex(1'b1, 1'b0, 32'd0);
        repeat (CntMax + 5) tick();
        set_ex(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if ({bus.flush_cnt, bus.retire_cnt} !== {CntW'(CntMax), CntW'(0)}) begin
            n_err++;
            $display("FAIL sat_flush: got flush=%0d retire=%0d want flush=%0d retire=0",
                     bus.flush_cnt, bus.retire_cnt, CntMax);
        end
    endtask

    // Reference model: list of instructions occupying EX(0), MEM(1), WB(2).
    typedef struct packed {
        logic       v;
        logic [4:0] rw;
        logic       wr;
        logic       ld;
    } ins_t;

    ins_t       m_pipe[3];
    logic       m_halt;
    logic [3:0] m_fwd;
    int         m_st, m_fl, m_ret;

    function automatic logic produces(input ins_t e, input logic [4:0] r);
        return e.v && e.wr && (e.rw == r) && (r != 5'd0);
    endfunction

    // Stage index (0 = EX, 1 = MEM) of the youngest producer of r, or -1.
    function automatic int nearest(input logic use_r, input logic [4:0] r);
        if (!use_r) return -1;
        for (int k = 0; k < 2; k++) begin
            if (produces(m_pipe[k], r)) return k;
        end
        return -1;
    endfunction

    task automatic test_random();
        logic [4:0] exp_ctrl;
        logic       haz;
        int         na, nb;
        do_reset();
        for (int k = 0; k < 3; k++) m_pipe[k] = '0;
        m_halt = 1'b0;
        m_fwd  = 4'b0;
        m_st   = 0;
        m_fl   = 0;
        m_ret  = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom_range(0, 2) == 0));
            set_ex(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 1) == 0) ? ExitCode : 32'($urandom_range(0, 12)));
            bus.go = 1'($urandom_range(0, 3) == 0);
            @(negedge clk);
            na  = nearest(bus.id_use_a, bus.id_ra);
            nb  = nearest(bus.id_use_b, bus.id_rb);
            haz = !m_halt && m_pipe[0].ld && (na == 0 || nb == 0);
            if (m_halt) exp_ctrl = 5'b00010;
            else if (bus.ex_jump) exp_ctrl = 5'b11111;
            else if (haz) exp_ctrl = 5'b00010;
            else exp_ctrl = 5'b11000;
            n_vec++;
            if (ctrl_vec() !== exp_ctrl) begin
                n_err++;
                $display("FAIL rnd_ctrl[%0d]: got %b want %b", cyc, ctrl_vec(), exp_ctrl);
            end
            n_vec++;
            if ({fwd_vec(), bus.halted} !== {m_fwd, m_halt}) begin
                n_err++;
                $display("FAIL rnd_fwd_halt[%0d]: got %b want %b", cyc, {fwd_vec(), bus.halted},
                         {m_fwd, m_halt});
            end
            n_vec++;
            if ({bus.stall_cnt, bus.flush_cnt, bus.retire_cnt} !==
                {CntW'(m_st), CntW'(m_fl), CntW'(m_ret)}) begin
                n_err++;
                $display("FAIL rnd_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", cyc,
                         bus.stall_cnt, bus.flush_cnt, bus.retire_cnt, m_st, m_fl, m_ret);
            end
            // Advance the model to the state after the coming clock edge.
            if (!m_halt) begin
                if (m_pipe[2].v) m_ret = (m_ret < CntMax) ? m_ret + 1 : m_ret;
                if (bus.ex_jump) m_fl = (m_fl < CntMax) ? m_fl + 1 : m_fl;
                else if (haz) m_st = (m_st < CntMax) ? m_st + 1 : m_st;
                if (exp_ctrl[1]) m_fwd = 4'b0000;
                else m_fwd = {na == 0, na == 1, nb == 0, nb == 1};
                m_pipe[2] = m_pipe[1];
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = exp_ctrl[1] ? '0 :
                            '{v: 1'b1, rw: bus.id_rw, wr: bus.id_regwrite, ld: bus.id_load};
                if (bus.ex_syscall && bus.ex_v0 == ExitCode && !bus.ex_jump) m_halt = 1'b1;
            end else if (bus.go) begin
                m_halt = 1'b0;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_zero_reg();
        test_jump_over_stall();
        test_halt();
        test_async_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Tracks destination registers of instructions in EX, MEM and WB, and drives registered forwarding selects into the ID/EX boundary: A_MEM, A_WB, B_MEM, B_WB.
- Detects load-use hazards and inserts stalls; flushes on taken jumps/branches resolved in EX; halts the pipe on the exit syscall.
- Keeps stall, flush and retire statistics counters for the FPGA display.

Parameters:
- CNT_W, 16, width of each statistics counter (saturating).
- EXIT_CODE, 32'h0000000A, $v0 value that makes an EX-stage syscall halt the core.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_ra  in  5  source register A of the instruction in ID (already muxed for syscall/EXTOP).
- id_rb  in  5  source register B of the instruction in ID.
- id_use_a  in  1  ID instruction reads id_ra.
- id_use_b  in  1  ID instruction reads id_rb.
- id_rw  in  5  destination of the ID instruction (after RegDst/jal muxing).
- id_regwrite  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load (MemToReg).
- ex_jump  in  1  taken jump/branch resolved in EX this cycle.
- ex_syscall  in  1  EX instruction is syscall.
- ex_v0  in  32  forwarded $v0 value seen by the EX syscall.
- go  in  1  resume pulse from HALT.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_bubble  out  1  ID/EX loads NOP.
- j_bub  out  1  PC source select: 1 = NPC_out (jump target).
- A_MEM, A_WB, B_MEM, B_WB  out  1 each  registered forwarding selects for the instruction in EX.
- halted  out  1  core is in HALT.
- stall_cnt, flush_cnt, retire_cnt  out  CNT_W each  statistics.

Behaviour:
- Tracker registers for the EX, MEM and WB stages, each holding {valid, rw, regwrite, load}.
- Every cycle not in HALT, the trackers shift: ID → EX → MEM → WB.
- When idex_bubble=1, the EX tracker loads invalid.
- A tracker entry counts only if valid && regwrite && rw != 0. $0 is never forwarded and never causes a stall.
- Forwarding selects, computed in ID and registered when ID→EX advances:
  - A_MEM = id_use_a && EX tracker matches id_ra.
  - A_WB = id_use_a && !A_MEM && MEM tracker matches id_ra.
  - B_MEM and B_WB are the same, using id_rb.
  - MEM has priority over WB. Selects are cleared to 0 whenever a bubble enters EX.
- WB→ID same-cycle reads are served by register-file write-through and are not handled here.
- Load-use stall:
  - Condition: the EX tracker is a load matching id_ra (with id_use_a) or id_rb (with id_use_b).
  - Response, combinational in that cycle: pc_en=0, ifid_en=0, idex_bubble=1. Exactly one stall cycle per load.
  - stall_cnt increments.
- Jump flush:
  - On ex_jump=1: j_bub=1, ifid_flush=1, idex_bubble=1, pc_en=1. flush_cnt increments.
  - ex_jump overrides a simultaneous load-use stall, because the stalled instruction is discarded. stall_cnt does not increment in that cycle.
- FSM states: RUN and HALT.
  - RUN → HALT on ex_syscall && ex_v0 == EXIT_CODE && !ex_jump. The syscall itself retires.
  - In HALT: pc_en=0, ifid_en=0, idex_bubble=1, trackers frozen, halted=1.
  - HALT → RUN on go=1. Normal operation resumes the next cycle.
  - go in RUN is ignored.
  - A syscall with any other $v0 does not halt.
- retire_cnt increments when a valid WB tracker entry is present and the FSM is in RUN.
- All counters saturate at all-ones.
- Output defaults in RUN with no hazard: pc_en=1, ifid_en=1, all other control outputs 0.
- Reset (asynchronous, at any time including mid-stall or in HALT):
  - FSM goes to RUN; all trackers invalid; forwarding selects 0; counters 0; halted=0.
  - pc_en=1, ifid_en=1; ifid_flush, idex_bubble and j_bub are 0.

Test Plan:
1. add $3,$1,$2 then sub $4,$3,$5 back-to-back → in sub's EX cycle A_MEM=1, A_WB=0; with one independent instruction between them → A_WB=1, A_MEM=0.
2. lw $8,0($0) followed by add $9,$8,$8 → exactly one cycle with pc_en=0, ifid_en=0, idex_bubble=1; then A_WB=1 and B_WB=1 for the add; stall_cnt=1.
3. Writer to $0 followed by reader of $0 → all forwarding selects 0, no stall.
4. ex_jump=1 in the same cycle as a load-use condition → j_bub=1, ifid_flush=1, idex_bubble=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
5. syscall with ex_v0=10 → halted=1 from the next cycle, pc_en=0 held for 20 cycles, retire_cnt frozen; go pulse → halted=0 the next cycle. Repeat with ex_v0=1 → no halt.
6. Assert rst during HALT and during a stall cycle → all outputs at their reset values immediately, without waiting for a clock edge; first cycle after deassertion shows pc_en=1.
